// File: rtl/diffeq_mul_scheduler.sv
// Euler-step scheduler for y'' + 3xy' + 3y = 0 (u = y').
// It sequences three products per iteration through one shared handshaked multiplier.
module diffeq_mul_scheduler #(
    parameter int W      = 16,
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [2:0]        in_sel,
    input  logic [W-1:0]      in_data,
    input  logic              start,
    output logic              mul_req,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic              mul_ack,
    input  logic [W-1:0]      mul_p,
    output logic              busy,
    output logic              valid,
    output logic              limit,
    output logic [W-1:0]      x_out,
    output logic [W-1:0]      y_out,
    output logic [W-1:0]      u_out,
    output logic [ITER_W-1:0] iter_count,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MUL1   = 3'd1,
        S_MUL2   = 3'd2,
        S_MUL3   = 3'd3,
        S_UPDATE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [ITER_W-1:0] ITER_MAX = '1;

    state_t      st;
    logic [W-1:0] x, y, u, dx, a;
    logic [W-1:0] p1, p2, p3;

    logic [W-1:0]      x_next;
    logic [W-1:0]      p2x3;
    logic [W-1:0]      p3x3;
    logic [W-1:0]      u_next;
    logic [ITER_W-1:0] iter_next;

    assign x_next    = x + dx;
    assign p2x3      = (p2 << 1) + p2;
    assign p3x3      = (p3 << 1) + p3;
    assign u_next    = u - p2x3 - p3x3;
    assign iter_next = iter_count + 1'b1;

    assign mul_req = (st == S_MUL1) || (st == S_MUL2) || (st == S_MUL3);
    assign busy    = mul_req || (st == S_UPDATE);
    assign valid   = (st == S_DONE);
    assign state   = st;
    assign x_out   = x;
    assign y_out   = y;
    assign u_out   = u;

    // Operands come straight from registers that cannot change while a request is open.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (st)
            S_MUL1: begin
                mul_a = u;
                mul_b = dx;
            end
            S_MUL2: begin
                mul_a = x;
                mul_b = p1;
            end
            S_MUL3: begin
                mul_a = y;
                mul_b = dx;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= S_IDLE;
            x          <= '0;
            y          <= '0;
            u          <= '0;
            dx         <= '0;
            a          <= '0;
            p1         <= '0;
            p2         <= '0;
            p3         <= '0;
            iter_count <= '0;
            limit      <= 1'b0;
        end else begin
            case (st)
                S_IDLE, S_DONE: begin
                    // A load in the same cycle as start wins; start is dropped.
                    if (in_valid) begin
                        case (in_sel)
                            3'd0:    x  <= in_data;
                            3'd1:    dx <= in_data;
                            3'd2:    a  <= in_data;
                            3'd3:    u  <= in_data;
                            3'd4:    y  <= in_data;
                            default: ;
                        endcase
                    end else if (start) begin
                        iter_count <= '0;
                        limit      <= 1'b0;
                        st         <= ($signed(x) >= $signed(a)) ? S_DONE : S_MUL1;
                    end
                end
                S_MUL1: begin
                    if (mul_ack) begin
                        p1 <= mul_p;
                        st <= S_MUL2;
                    end
                end
                S_MUL2: begin
                    if (mul_ack) begin
                        p2 <= mul_p;
                        st <= S_MUL3;
                    end
                end
                S_MUL3: begin
                    if (mul_ack) begin
                        p3 <= mul_p;
                        st <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    u          <= u_next;
                    y          <= y + p1;
                    x          <= x_next;
                    iter_count <= iter_next;
                    // Reaching a takes priority over the iteration cap when both hit together.
                    if ($signed(x_next) >= $signed(a)) begin
                        st <= S_DONE;
                    end else if (iter_next < ITER_MAX) begin
                        st <= S_MUL1;
                    end else begin
                        st    <= S_DONE;
                        limit <= 1'b1;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_diffeq_mul_scheduler.sv
// Directed bench for diffeq_mul_scheduler with a behavioural multiplier of programmable ack delay.
module tb_diffeq_mul_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  in_sel = '0;
    logic [15:0] in_data = '0;
    logic        start = 1'b0;
    logic        mul_req;
    logic [15:0] mul_a, mul_b;
    logic        mul_ack;
    logic [15:0] mul_p;
    logic        busy, valid, limit;
    logic [15:0] x_out, y_out, u_out;
    logic [2:0]  iter_count;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    int   ack_delay = 0;
    int   wait_cnt = 0;
    logic force_ack = 1'b0;
    logic [31:0] prod;

    diffeq_mul_scheduler #(.W(16), .ITER_W(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data),
        .start(start), .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_ack(mul_ack),
        .mul_p(mul_p), .busy(busy), .valid(valid), .limit(limit), .x_out(x_out),
        .y_out(y_out), .u_out(u_out), .iter_count(iter_count), .state(state)
    );

    always #5 clk = ~clk;

    // Multiplier model: answers after ack_delay waiting cycles of an open request.
    assign prod    = mul_a * mul_b;
    assign mul_p   = prod[15:0];
    assign mul_ack = force_ack | (mul_req && (wait_cnt >= ack_delay));

    always @(posedge clk) begin
        if (!mul_req || mul_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    task automatic load(input logic [2:0] sel, input logic [15:0] data);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load_all(input logic [15:0] x, input logic [15:0] dx, input logic [15:0] a,
                            input logic [15:0] u, input logic [15:0] y);
        load(3'd0, x);
        load(3'd1, dx);
        load(3'd2, a);
        load(3'd3, u);
        load(3'd4, y);
    endtask

    task automatic launch();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts clock edges from the start edge (already counted as start_cnt) until valid.
    task automatic wait_valid(input int start_cnt, output int cycles);
        cycles = start_cnt;
        while (!valid && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL reset state: got %0d expected 0", state); end
        checks++; if ({mul_req, busy, valid, limit} !== 4'b0000) begin errors++; $display("[TB] FAIL reset flags: got %b expected 0000", {mul_req, busy, valid, limit}); end
        checks++; if ({x_out, y_out, u_out} !== 48'd0) begin errors++; $display("[TB] FAIL reset regs: got %h expected 0", {x_out, y_out, u_out}); end
        checks++; if (iter_count !== 3'd0) begin errors++; $display("[TB] FAIL reset iter: got %0d expected 0", iter_count); end
        checks++; if ({mul_a, mul_b} !== 32'd0) begin errors++; $display("[TB] FAIL reset operands: got %h expected 0", {mul_a, mul_b}); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int cycles;
        load_all(16'd0, 16'd1, 16'd3, 16'd1, 16'd0);
        launch();
        checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL basic first state: got %0d expected 1", state); end
        checks++; if ({mul_a, mul_b} !== {16'd1, 16'd1}) begin errors++; $display("[TB] FAIL basic mul1 operands: got %h expected 00010001", {mul_a, mul_b}); end
        wait_valid(1, cycles);
        checks++; if (cycles != 13) begin errors++; $display("[TB] FAIL basic latency: got %0d expected 13", cycles); end
        checks++; if (x_out !== 16'd3) begin errors++; $display("[TB] FAIL basic x: got %h expected 0003", x_out); end
        checks++; if (y_out !== 16'hFFFD) begin errors++; $display("[TB] FAIL basic y: got %h expected fffd", y_out); end
        checks++; if (u_out !== 16'd19) begin errors++; $display("[TB] FAIL basic u: got %0d expected 19", u_out); end
        checks++; if (iter_count !== 3'd3) begin errors++; $display("[TB] FAIL basic iter: got %0d expected 3", iter_count); end
        checks++; if ({state, busy, limit} !== {3'd5, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL basic done flags: got %b expected 10100", {state, busy, limit}); end
    endtask

    task automatic test_zero_iter();
        logic saw_req;
        load(3'd0, 16'd5);
        launch();
        saw_req = mul_req;
        checks++; if ({valid, state} !== {1'b1, 3'd5}) begin errors++; $display("[TB] FAIL zero valid: got %b expected 1101", {valid, state}); end
        checks++; if (iter_count !== 3'd0) begin errors++; $display("[TB] FAIL zero iter: got %0d expected 0", iter_count); end
        repeat (3) begin
            @(posedge clk); #1;
            saw_req = saw_req | mul_req;
        end
        checks++; if (saw_req !== 1'b0) begin errors++; $display("[TB] FAIL zero mul_req: got %b expected 0", saw_req); end
        checks++; if ({x_out, y_out, u_out} !== {16'd5, 16'hFFFD, 16'd19}) begin errors++; $display("[TB] FAIL zero regs: got %h expected 0005fffd0013", {x_out, y_out, u_out}); end
    endtask

    task automatic test_signed_compare();
        int cycles;
        load_all(16'hFFFF, 16'd1, 16'd1, 16'd0, 16'd0);
        launch();
        wait_valid(1, cycles);
        checks++; if (cycles != 9) begin errors++; $display("[TB] FAIL signed latency: got %0d expected 9", cycles); end
        checks++; if ({x_out, iter_count} !== {16'd1, 3'd2}) begin errors++; $display("[TB] FAIL signed result: got x=%h iter=%0d expected x=0001 iter=2", x_out, iter_count); end
    endtask

    task automatic test_stall();
        int          cycles;
        logic        stable_ok, prev_req;
        logic [15:0] prev_a, prev_b;
        logic [2:0]  prev_st;
        ack_delay = 3;
        load_all(16'd0, 16'd1, 16'd3, 16'd1, 16'd0);
        launch();
        cycles    = 1;
        stable_ok = 1'b1;
        prev_req  = mul_req;
        prev_a    = mul_a;
        prev_b    = mul_b;
        prev_st   = state;
        while (!valid && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
            if (mul_req && prev_req && state == prev_st && (mul_a !== prev_a || mul_b !== prev_b))
                stable_ok = 1'b0;
            prev_req = mul_req;
            prev_a   = mul_a;
            prev_b   = mul_b;
            prev_st  = state;
        end
        ack_delay = 0;
        checks++; if (cycles != 40) begin errors++; $display("[TB] FAIL stall latency: got %0d expected 40", cycles); end
        checks++; if (stable_ok !== 1'b1) begin errors++; $display("[TB] FAIL stall operand stability: got %b expected 1", stable_ok); end
        checks++; if ({x_out, y_out, u_out} !== {16'd3, 16'hFFFD, 16'd19}) begin errors++; $display("[TB] FAIL stall regs: got %h expected 0003fffd0013", {x_out, y_out, u_out}); end
        checks++; if (iter_count !== 3'd3) begin errors++; $display("[TB] FAIL stall iter: got %0d expected 3", iter_count); end
    endtask

    task automatic test_limit();
        int cycles;
        load_all(16'd0, 16'd1, 16'd100, 16'd0, 16'd0);
        launch();
        wait_valid(1, cycles);
        checks++; if (cycles != 29) begin errors++; $display("[TB] FAIL limit latency: got %0d expected 29", cycles); end
        checks++; if ({limit, x_out, iter_count} !== {1'b1, 16'd7, 3'd7}) begin errors++; $display("[TB] FAIL limit result: got limit=%b x=%0d iter=%0d expected limit=1 x=7 iter=7", limit, x_out, iter_count); end
        // Reaching a on the last permitted iteration is a normal finish.
        load_all(16'd0, 16'd1, 16'd7, 16'd0, 16'd0);
        launch();
        wait_valid(1, cycles);
        checks++; if ({limit, x_out, iter_count} !== {1'b0, 16'd7, 3'd7}) begin errors++; $display("[TB] FAIL limit boundary: got limit=%b x=%0d iter=%0d expected limit=0 x=7 iter=7", limit, x_out, iter_count); end
    endtask

    task automatic test_reset_mid_run();
        int cycles;
        ack_delay = 3;
        load_all(16'd0, 16'd1, 16'd3, 16'd1, 16'd0);
        launch();
        cycles = 1;
        while (!(state == 3'd2 && iter_count == 3'd1) && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
        end
        checks++; if (state !== 3'd2) begin errors++; $display("[TB] FAIL midrun reach MUL2: got state %0d expected 2", state); end
        reset     = 1'b1;
        force_ack = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if ({state, mul_req, busy, valid, limit} !== 7'd0) begin errors++; $display("[TB] FAIL midrun reset flags: got %b expected 0000000", {state, mul_req, busy, valid, limit}); end
        checks++; if ({x_out, y_out, u_out, iter_count} !== 51'd0) begin errors++; $display("[TB] FAIL midrun reset regs: got %h expected 0", {x_out, y_out, u_out, iter_count}); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({state, x_out, y_out, u_out, iter_count} !== 54'd0) begin errors++; $display("[TB] FAIL midrun late ack: got %h expected 0", {state, x_out, y_out, u_out, iter_count}); end
        force_ack = 1'b0;
        ack_delay = 0;
    endtask

    task automatic test_load_rules();
        int cycles;
        start    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 3'd0;
        in_data  = 16'hFFFE;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        checks++; if ({state, x_out} !== {3'd0, 16'hFFFE}) begin errors++; $display("[TB] FAIL load start+write: got state=%0d x=%h expected state=0 x=fffe", state, x_out); end
        load(3'd1, 16'd1);
        load(3'd2, 16'd1);
        load(3'd3, 16'd0);
        load(3'd4, 16'd0);
        launch();
        in_valid = 1'b1;
        in_sel   = 3'd0;
        in_data  = 16'h1234;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(2, cycles);
        checks++; if ({x_out, iter_count} !== {16'd1, 3'd3}) begin errors++; $display("[TB] FAIL load busy ignored: got x=%h iter=%0d expected x=0001 iter=3", x_out, iter_count); end
        load(3'd5, 16'h0055);
        checks++; if ({x_out, y_out, u_out, valid} !== {16'd1, 16'd0, 16'd0, 1'b1}) begin errors++; $display("[TB] FAIL load sel5 ignored: got %h expected 0001000000001", {x_out, y_out, u_out, valid}); end
        load_all(16'd0, 16'd1, 16'd3, 16'd1, 16'd0);
        launch();
        checks++; if ({valid, state} !== {1'b0, 3'd1}) begin errors++; $display("[TB] FAIL rerun clears valid: got %b expected 0001", {valid, state}); end
        wait_valid(1, cycles);
        checks++; if (cycles != 13) begin errors++; $display("[TB] FAIL rerun latency: got %0d expected 13", cycles); end
        checks++; if ({x_out, y_out, u_out} !== {16'd3, 16'hFFFD, 16'd19}) begin errors++; $display("[TB] FAIL rerun regs: got %h expected 0003fffd0013", {x_out, y_out, u_out}); end
    endtask

    initial begin
        $display("[TB] starting diffeq_mul_scheduler bench");
        test_reset();
        test_basic();
        test_zero_iter();
        test_signed_compare();
        test_stall();
        test_limit();
        test_reset_mid_run();
        test_load_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/diffeq_mul_scheduler.md
# diffeq_mul_scheduler

Iteration scheduler for the differential-equation solver datapath. It holds the solver state (x, y, u, dx, a) and runs the Euler update loop y'' + 3xy' + 3y = 0, with u = y'. All multiplications go through one external multi-cycle multiplier, accessed over a req/ack handshake. It sits between the operand-load front end and the shared multiplier. It replaces per-step compute_done polling with a self-sequenced loop that reports completion on `valid`.

## Interface
Parameters:
- W, 16, data width (signed two's complement) of all operands, results and multiplier ports
- ITER_W, 8, width of the iteration counter; the iteration limit is 2^ITER_W-1

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- in_valid  in  1  operand write strobe
- in_sel  in  3  operand select: 0=x, 1=dx, 2=a, 3=u, 4=y; 5-7 are ignored
- in_data  in  W  operand value
- start  in  1  launches a run (single-cycle pulse or level; sampled only when the run can be launched)
- mul_req  out  1  multiply request
- mul_a, mul_b  out  W  multiplier operands
- mul_ack  in  1  multiplier completion; mul_p is valid in the same cycle
- mul_p  in  W  low W bits of mul_a*mul_b
- busy  out  1  high in MUL1, MUL2, MUL3 and UPDATE
- valid  out  1  high in DONE
- limit  out  1  the last run stopped on the iteration limit rather than x>=a
- x_out, y_out, u_out  out  W  current x, y, u registers
- iter_count  out  ITER_W  iterations completed in the current or last run
- state  out  3  current state encoding

## Operation
States and encodings: IDLE=0, MUL1=1, MUL2=2, MUL3=3, UPDATE=4, DONE=5.

Operand loads:
- Accepted only in IDLE and DONE: with in_valid=1, register[in_sel] <= in_data.
- Ignored in all other states.

Launching a run:
- start is honoured in IDLE or DONE only when in_valid=0; start with in_valid=1 in the same cycle is ignored.
- On an honoured start: iter_count<=0, limit<=0.
- If x >= a (signed), go to DONE immediately (zero iterations).
- Otherwise go to MUL1.

Per-iteration multiply sequence:
- MUL1: mul_a=u, mul_b=dx. On ack, P1<=mul_p.
- MUL2: mul_a=x, mul_b=P1. On ack, P2<=mul_p.
- MUL3: mul_a=y, mul_b=dx. On ack, P3<=mul_p.

UPDATE (one cycle, all right-hand sides use old register values):
- u <= u - 3*P2 - 3*P3, where 3*z is computed as (z<<1)+z.
- y <= y + P1.
- x <= x + dx.
- iter_count += 1.
- All arithmetic wraps modulo 2^W. Overflow is not flagged.

UPDATE exit:
- If (x+dx) < a (signed) and iter_count+1 < 2^ITER_W-1, go to MUL1.
- If (x+dx) >= a, go to DONE.
- Otherwise go to DONE with limit<=1.

DONE:
- Holds results and valid=1 until an honoured start or reset.

## Timing
Reset:
- state=IDLE.
- x, y, u, dx, a, P1..P3 and iter_count are all 0.
- mul_req=0, busy=0, valid=0, limit=0.

Handshake:
- mul_req is decoded from state: 1 in MUL1/2/3, 0 elsewhere.
- mul_a and mul_b are stable for as long as mul_req=1.
- The transition to the next state happens on the edge where mul_ack=1.
- A same-cycle ack is legal, giving a minimum of 1 cycle per MUL state.
- mul_ack is ignored whenever mul_req=0.
- Back-to-back MUL states present the new operands in the cycle after the ack.

Latency:
- With a zero-wait multiplier, one iteration takes 4 cycles.
- valid rises 1+4N cycles after the start edge for N iterations.
- The zero-iteration case takes 1 cycle.
- Each extra wait cycle of ack adds 1 cycle.

Reset mid-run:
- On the next edge the block returns to reset values and mul_req=0.
- A late mul_ack after that edge is ignored.

The comparison is signed. For example, x=-1 (all ones) is less than a=1.

## Test plan
- Basic run: W=16, load x=0, dx=1, a=3, u=1, y=0, start, zero-wait ack -> valid rises 13 cycles after start with x_out=3, y_out=-3 (0xFFFD), u_out=19, iter_count=3, limit=0.
- Zero iterations: x=5, a=3, start -> next cycle valid=1, iter_count=0, mul_req never asserts, outputs unchanged.
- Multiplier stalls: repeat the basic run with ack delayed 3 cycles per request -> identical results; mul_a/mul_b stable throughout each request; valid rises at cycle 1+3*(1+3*4)=40.
- Iteration limit: ITER_W=3, dx=1, x=0, a=100 -> DONE after 7 iterations with limit=1, x_out=7.
- Reset mid-run: assert reset during MUL2 of iteration 2 -> next edge state=0, all outputs 0, mul_req=0; an ack held high afterwards causes no change.
- Load rules: in_valid during busy leaves registers unchanged; start with in_valid=1 in IDLE -> no launch, operand written; a second start from DONE clears valid and reruns from the loaded registers.
